dnc_write_heads_unpacker: RTL
=============================

# dnc_write_heads_unpacker

Parametrised successor to the single-head DNC write-head interface. It accepts the controller's interface vector as a stream of fixed-point elements, covering up to H write heads. It splits the stream per head into write key k, write strength beta, erase vector e, write vector v, allocation gate ga and write gate gw, and applies the DNC activations (oneplus, sigmoid) in hardware using saturating fixed-point approximations. It sits between the controller output layer and the memory write path.

## Interface
- DATA_SIZE, 64, element width, two's complement fixed point
- FRAC_SIZE, 32, fractional bits; ONE = 1<<FRAC_SIZE
- W, 64, maximum word width (elements in k, e, v)
- H, 4, maximum number of write heads
- CLK  in  1  clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  begin a frame; sampled only in IDLE
- READY  out  1  one-cycle pulse at end of frame
- SIZE_W_IN  in  DATA_SIZE  runtime word width, sampled at START
- SIZE_H_IN  in  DATA_SIZE  runtime head count, sampled at START
- XI_IN_ENABLE  in  1  XI_IN valid this cycle
- XI_IN  in  DATA_SIZE  interface-vector element
- HEAD_OUT  out  log2(H) (min 1)  head index of the current output
- INDEX_OUT  out  log2(W) (min 1)  element index within k/e/v
- K_OUT_ENABLE, BETA_OUT_ENABLE, E_OUT_ENABLE, V_OUT_ENABLE, GA_OUT_ENABLE, GW_OUT_ENABLE  out  1 each  output-valid strobes, at most one high per cycle
- K_OUT, BETA_OUT, E_OUT, V_OUT, GA_OUT, GW_OUT  out  DATA_SIZE each  registered results; each holds its last value until it is next written

## Operation
- States: IDLE, KEY, BETA, ERASE, VECTOR, GA, GW.
- Per-head element order: k[0..Ws-1], beta, e[0..Ws-1], v[0..Ws-1], ga, gw, giving 3*Ws+3 elements per head.
- Ws = min(SIZE_W_IN, W); Hs = min(SIZE_H_IN, H). Both are latched at START.
- START in IDLE with Hs=0: READY pulses on the next cycle and the block stays in IDLE.
- START in IDLE with Ws=0: the KEY, ERASE and VECTOR phases are skipped, so each head consumes beta, ga, gw only.
- START outside IDLE is ignored. Latched sizes do not change mid-frame.
- An element is consumed only when XI_IN_ENABLE=1 and state≠IDLE. Gaps of any length are allowed. XI_IN_ENABLE in IDLE is ignored.
- The element counter advances per consumed element. At Ws-1 the state moves to the next phase and the counter clears.
- After GW the head counter increments. The state returns to KEY (or BETA when Ws=0), or to IDLE after head Hs-1.
- k, v: passthrough.
- beta (oneplus approximation): ONE + max(x,0). On positive overflow, saturate to 2^(DATA_SIZE-1)-1.
- e, ga, gw (hard sigmoid): clamp((x>>>2) + ONE/2, 0, ONE). The shift is arithmetic. The intermediate is computed with one guard bit so it cannot wrap.
- Reset (at any time, including mid-frame): state IDLE, counters 0, READY 0, all enables 0, all data outputs 0, HEAD_OUT 0, INDEX_OUT 0. A partial frame is discarded.

## Timing
- Latency is 1 cycle: an element consumed at edge t drives the matching *_OUT and *_OUT_ENABLE on t+1, together with HEAD_OUT and INDEX_OUT.
- Enables are single-cycle per consumed element. Back-to-back input gives back-to-back output.
- READY pulses in the same cycle as the final GW_OUT_ENABLE of head Hs-1. State is IDLE in that cycle, so a START in that same cycle is accepted and a new frame may start with zero bubble.
- INDEX_OUT is 0 for the beta, ga and gw outputs.
- Throughput: 1 element per cycle, with no backpressure.

## Test plan
- Reset values: hold RST high mid-frame (Ws=2, Hs=1, after 3 elements) → all outputs 0 and READY 0. After release, a new START processes a full frame correctly.
- Single head, Ws=2, FRAC_SIZE=32, stream k={5,-5}, beta=0x2_0000_0000, e={0, 0x4_0000_0000}, v={7,8}, ga=-0x8_0000_0000, gw=0 → K_OUT 5,-5; BETA_OUT 0x3_0000_0000; E_OUT 0x8000_0000, 0x1_0000_0000; V_OUT 7,8; GA_OUT 0; GW_OUT 0x8000_0000; READY together with GW_OUT_ENABLE.
- Saturation: beta=0x7FFF_FFFF_FFFF_FFFF → BETA_OUT 0x7FFF_FFFF_FFFF_FFFF. beta=-3*ONE → BETA_OUT ONE.
- Multi-head with gaps: Hs=3, Ws=4, random XI_IN_ENABLE density of 50% → 45 outputs total, HEAD_OUT and INDEX_OUT sequence correct, exactly one READY pulse.
- Boundaries: Ws=0, Hs=2 → only beta, ga, gw per head (6 outputs). Hs=0 → READY one cycle after START with no enables. SIZE_W_IN=W+10 → behaves as W.
- Back-to-back frames: START asserted in the READY cycle → the second frame starts with no idle cycle. START asserted mid-frame is ignored and the first frame's output is unaffected.

Source files
------------

// File: rtl/dnc_write_heads_unpacker_if.sv
// Stream/result bundle between the controller output layer and the write-head unpacker.
// The master side drives the interface-vector stream; the slave side returns per-head fields.
interface dnc_write_heads_unpacker_if #(
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned W         = 64,
    parameter int unsigned H         = 4
);
    localparam int unsigned HW = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    logic                 start;
    logic [DATA_SIZE-1:0] size_w;
    logic [DATA_SIZE-1:0] size_h;
    logic                 xi_en;
    logic [DATA_SIZE-1:0] xi;

    logic                 ready;
    logic [HW-1:0]        head;
    logic [IW-1:0]        index;
    logic                 k_en, beta_en, e_en, v_en, ga_en, gw_en;
    logic [DATA_SIZE-1:0] k, beta, e, v, ga, gw;

    modport master (
        output start, size_w, size_h, xi_en, xi,
        input  ready, head, index,
        input  k_en, beta_en, e_en, v_en, ga_en, gw_en,
        input  k, beta, e, v, ga, gw
    );

    modport slave (
        input  start, size_w, size_h, xi_en, xi,
        output ready, head, index,
        output k_en, beta_en, e_en, v_en, ga_en, gw_en,
        output k, beta, e, v, ga, gw
    );
endinterface

// File: rtl/dnc_write_heads_unpacker.sv
// Splits the DNC interface-vector stream into per-head write fields (k, beta, e, v, ga, gw),
// applying saturating oneplus to beta and a hard sigmoid to e/ga/gw, with one cycle of latency.
module dnc_write_heads_unpacker #(
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned FRAC_SIZE = 32,
    parameter int unsigned W         = 64,
    parameter int unsigned H         = 4
) (
    input logic                      clk_i,
    input logic                      rst_i,
    dnc_write_heads_unpacker_if.slave bus
);
    localparam int unsigned HW  = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned IW  = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned WsW = $clog2(W + 1);
    localparam int unsigned HsW = $clog2(H + 1);

    localparam logic [DATA_SIZE-1:0] One    = DATA_SIZE'(1) << FRAC_SIZE;
    localparam logic [DATA_SIZE-1:0] Half   = One >> 1;
    localparam logic [DATA_SIZE-1:0] MaxPos = {1'b0, {(DATA_SIZE - 1){1'b1}}};

    typedef enum logic [2:0] {StIdle, StKey, StBeta, StErase, StVector, StGa, StGw} state_e;

    function automatic logic [DATA_SIZE-1:0] oneplus(input logic [DATA_SIZE-1:0] x);
        logic [DATA_SIZE:0] sum;
        if (x[DATA_SIZE-1]) return One;
        sum = {1'b0, x} + {1'b0, One};
        if (sum[DATA_SIZE] || sum[DATA_SIZE-1]) return MaxPos;
        return sum[DATA_SIZE-1:0];
    endfunction

    // Guard bit keeps (x>>>2)+ONE/2 from wrapping before the clamp.
    function automatic logic [DATA_SIZE-1:0] hard_sigmoid(input logic [DATA_SIZE-1:0] x);
        logic [DATA_SIZE:0] t;
        t = {{3{x[DATA_SIZE-1]}}, x[DATA_SIZE-1:2]} + {1'b0, Half};
        if (t[DATA_SIZE]) return '0;
        if (t[DATA_SIZE-1:0] > One) return One;
        return t[DATA_SIZE-1:0];
    endfunction

    state_e               state_q;
    logic [WsW-1:0]       ws_q, cnt_q, ws_in;
    logic [HsW-1:0]       hs_q, hcnt_q, hs_in;
    logic                 ready_q;
    logic [HW-1:0]        head_q;
    logic [IW-1:0]        index_q;
    logic                 k_en_q, beta_en_q, e_en_q, v_en_q, ga_en_q, gw_en_q;
    logic [DATA_SIZE-1:0] k_q, beta_q, e_q, v_q, ga_q, gw_q;
    logic                 last_w, last_h;

    assign ws_in  = (bus.size_w > DATA_SIZE'(W)) ? WsW'(W) : bus.size_w[WsW-1:0];
    assign hs_in  = (bus.size_h > DATA_SIZE'(H)) ? HsW'(H) : bus.size_h[HsW-1:0];
    assign last_w = (cnt_q == ws_q - WsW'(1));
    assign last_h = (hcnt_q == hs_q - HsW'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ws_q      <= '0;
            hs_q      <= '0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            ready_q   <= 1'b0;
            head_q    <= '0;
            index_q   <= '0;
            k_en_q    <= 1'b0;
            beta_en_q <= 1'b0;
            e_en_q    <= 1'b0;
            v_en_q    <= 1'b0;
            ga_en_q   <= 1'b0;
            gw_en_q   <= 1'b0;
            k_q       <= '0;
            beta_q    <= '0;
            e_q       <= '0;
            v_q       <= '0;
            ga_q      <= '0;
            gw_q      <= '0;
        end else begin
            ready_q   <= 1'b0;
            k_en_q    <= 1'b0;
            beta_en_q <= 1'b0;
            e_en_q    <= 1'b0;
            v_en_q    <= 1'b0;
            ga_en_q   <= 1'b0;
            gw_en_q   <= 1'b0;
            if (state_q == StIdle) begin
                if (bus.start) begin
                    ws_q   <= ws_in;
                    hs_q   <= hs_in;
                    cnt_q  <= '0;
                    hcnt_q <= '0;
                    if (hs_in == '0) ready_q <= 1'b1;
                    else if (ws_in == '0) state_q <= StBeta;
                    else state_q <= StKey;
                end
            end else if (bus.xi_en) begin
                head_q  <= hcnt_q[HW-1:0];
                index_q <= '0;
                unique case (state_q)
                    StKey: begin
                        k_q     <= bus.xi;
                        k_en_q  <= 1'b1;
                        index_q <= cnt_q[IW-1:0];
                        cnt_q   <= last_w ? '0 : cnt_q + WsW'(1);
                        if (last_w) state_q <= StBeta;
                    end
                    StBeta: begin
                        beta_q    <= oneplus(bus.xi);
                        beta_en_q <= 1'b1;
                        state_q   <= (ws_q == '0) ? StGa : StErase;
                    end
                    StErase: begin
                        e_q     <= hard_sigmoid(bus.xi);
                        e_en_q  <= 1'b1;
                        index_q <= cnt_q[IW-1:0];
                        cnt_q   <= last_w ? '0 : cnt_q + WsW'(1);
                        if (last_w) state_q <= StVector;
                    end
                    StVector: begin
                        v_q     <= bus.xi;
                        v_en_q  <= 1'b1;
                        index_q <= cnt_q[IW-1:0];
                        cnt_q   <= last_w ? '0 : cnt_q + WsW'(1);
                        if (last_w) state_q <= StGa;
                    end
                    StGa: begin
                        ga_q    <= hard_sigmoid(bus.xi);
                        ga_en_q <= 1'b1;
                        state_q <= StGw;
                    end
                    StGw: begin
                        gw_q    <= hard_sigmoid(bus.xi);
                        gw_en_q <= 1'b1;
                        if (last_h) begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                        end else begin
                            hcnt_q  <= hcnt_q + HsW'(1);
                            state_q <= (ws_q == '0) ? StBeta : StKey;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.ready   = ready_q;
    assign bus.head    = head_q;
    assign bus.index   = index_q;
    assign bus.k_en    = k_en_q;
    assign bus.beta_en = beta_en_q;
    assign bus.e_en    = e_en_q;
    assign bus.v_en    = v_en_q;
    assign bus.ga_en   = ga_en_q;
    assign bus.gw_en   = gw_en_q;
    assign bus.k       = k_q;
    assign bus.beta    = beta_q;
    assign bus.e       = e_q;
    assign bus.v       = v_q;
    assign bus.ga      = ga_q;
    assign bus.gw      = gw_q;
endmodule
